// File: rtl/keypad_scan_fifo.sv
// Matrix-keypad scanner: walks one active-low drive line at a time, debounces press and
// release on scan ticks, and queues accepted key codes in a show-ahead FIFO with interrupt.
module keypad_scan_fifo #(
  parameter int unsigned NUM_DRIVE  = 4,
  parameter int unsigned NUM_SENSE  = 3,
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned DEBOUNCE   = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned INT_MODE   = 0,
  localparam int unsigned CODE_W = (NUM_DRIVE * NUM_SENSE > 1) ?
                                   $clog2(NUM_DRIVE * NUM_SENSE) : 1,
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_SENSE-1:0] sense_n,
  output logic [NUM_DRIVE-1:0] drive_n,
  output logic                 key_valid,
  output logic [CODE_W-1:0]    key_code,
  input  logic                 key_rd,
  output logic [CNT_W-1:0]     fifo_count,
  output logic [CODE_W-1:0]    last_key,
  output logic                 overflow,
  output logic                 interrupt
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W = (NUM_DRIVE > 1) ? $clog2(NUM_DRIVE) : 1;
  localparam int unsigned COL_W = (NUM_SENSE > 1) ? $clog2(NUM_SENSE) : 1;
  localparam int unsigned DBC_W = $clog2(DEBOUNCE + 1);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {StScan, StPressDb, StHeld, StRelDb} state_e;

  logic [NUM_SENSE-1:0] sync1_q, s_n;
  logic [DIV_W-1:0]     div_q;
  logic                 tick;
  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d, idx_next;
  logic [DBC_W-1:0]     dbc_q, dbc_d, dbc_inc;
  logic [COL_W-1:0]     col_q, col_d, low_col;
  logic [CODE_W-1:0]    code_q, code_d, cap_code;
  logic [CODE_W-1:0]    last_key_q, last_key_d;
  logic                 any_low;
  logic                 push_q, push_d;

  logic [CODE_W-1:0]    mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 full, do_push, do_pop;
  logic                 ovf_q, irq_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      s_n     <= '1;
    end else begin
      sync1_q <= sense_n;
      s_n     <= sync1_q;
    end
  end

  assign tick = (div_q == DIV_W'(SCAN_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_q <= '0;
    else        div_q <= tick ? '0 : div_q + DIV_W'(1);
  end

  // Lowest-numbered closed sense line wins when several keys share a row.
  always_comb begin
    any_low = 1'b0;
    low_col = '0;
    for (int i = NUM_SENSE - 1; i >= 0; i--) begin
      if (!s_n[i]) begin
        any_low = 1'b1;
        low_col = COL_W'(i);
      end
    end
  end

  assign idx_next = (idx_q == IDX_W'(NUM_DRIVE - 1)) ? '0 : idx_q + IDX_W'(1);
  assign dbc_inc  = dbc_q + DBC_W'(1);
  assign cap_code = CODE_W'(32'(idx_q) * NUM_SENSE + 32'(low_col));

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    dbc_d      = dbc_q;
    col_d      = col_q;
    code_d     = code_q;
    last_key_d = last_key_q;
    push_d     = 1'b0;
    if (tick) begin
      case (state_q)
        StScan: begin
          if (any_low) begin
            code_d = cap_code;
            col_d  = low_col;
            dbc_d  = DBC_W'(1);
            if (DEBOUNCE == 1) begin
              state_d    = StHeld;
              push_d     = 1'b1;
              last_key_d = cap_code;
            end else begin
              state_d = StPressDb;
            end
          end else begin
            idx_d = idx_next;
          end
        end
        StPressDb: begin
          if (any_low && (low_col == col_q)) begin
            dbc_d = dbc_inc;
            if (dbc_inc == DBC_W'(DEBOUNCE)) begin
              state_d    = StHeld;
              push_d     = 1'b1;
              last_key_d = code_q;
            end
          end else begin
            state_d = StScan;
          end
        end
        StHeld: begin
          if (!any_low) begin
            dbc_d = DBC_W'(1);
            if (DEBOUNCE == 1) begin
              state_d = StScan;
              idx_d   = idx_next;
            end else begin
              state_d = StRelDb;
            end
          end
        end
        StRelDb: begin
          if (!any_low) begin
            dbc_d = dbc_inc;
            if (dbc_inc == DBC_W'(DEBOUNCE)) begin
              state_d = StScan;
              idx_d   = idx_next;
            end
          end else begin
            state_d = StHeld;
          end
        end
        default: state_d = StScan;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StScan;
      idx_q      <= '0;
      dbc_q      <= '0;
      col_q      <= '0;
      code_q     <= '0;
      last_key_q <= '0;
      push_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      dbc_q      <= dbc_d;
      col_q      <= col_d;
      code_q     <= code_d;
      last_key_q <= last_key_d;
      push_q     <= push_d;
    end
  end

  assign drive_n = ~(NUM_DRIVE'(1) << idx_q);

  assign key_valid = (count_q != '0);
  assign full      = (count_q == CNT_W'(FIFO_DEPTH));
  assign do_pop    = key_rd && key_valid;
  // A pop on the same clk frees the slot, so a push into a full FIFO still lands.
  assign do_push   = push_q && (!full || do_pop);

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
    else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= code_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      if (do_pop)              ovf_q <= 1'b0;
      else if (push_q && full) ovf_q <= 1'b1;
      irq_q <= (INT_MODE == 0) ? (count_d != '0) : do_push;
    end
  end

  assign key_code   = mem_q[rd_ptr_q];
  assign fifo_count = count_q;
  assign last_key   = last_key_q;
  assign overflow   = ovf_q;
  assign interrupt  = irq_q;

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Bench for keypad_scan_fifo: emulated keypad matrix, queue-based FIFO model, directed
// scenarios followed by random presses and reads.
module tb_keypad_scan_fifo;

  localparam int unsigned ND = 4;
  localparam int unsigned NS = 3;
  localparam int unsigned SD = 4;
  localparam int unsigned DB = 3;
  localparam int unsigned FD = 4;
  localparam int unsigned CW = 4;
  localparam int unsigned NW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic key_rd = 1'b0;
  logic pressed = 1'b0;
  int   key = 0;

  logic [NS-1:0] sense0, sense1;
  logic [ND-1:0] drive0, drive1;
  logic          kv0, kv1, ovf0, ovf1, irq0, irq1;
  logic [CW-1:0] code0, code1, last0, last1;
  logic [NW-1:0] cnt0, cnt1;

  int errors = 0;
  int checks = 0;
  int unsigned edge_cnt;
  int   q[$];
  int   exp_ovf, exp_last, exp_pulses;
  int   pulses;
  logic long_pulse, irq1_prev;

  always #5 clk = ~clk;

  keypad_scan_fifo #(
    .NUM_DRIVE(ND), .NUM_SENSE(NS), .SCAN_DIV(SD), .DEBOUNCE(DB),
    .FIFO_DEPTH(FD), .INT_MODE(0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .sense_n(sense0), .drive_n(drive0), .key_valid(kv0),
    .key_code(code0), .key_rd(key_rd), .fifo_count(cnt0), .last_key(last0),
    .overflow(ovf0), .interrupt(irq0)
  );

  keypad_scan_fifo #(
    .NUM_DRIVE(ND), .NUM_SENSE(NS), .SCAN_DIV(SD), .DEBOUNCE(DB),
    .FIFO_DEPTH(FD), .INT_MODE(1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .sense_n(sense1), .drive_n(drive1), .key_valid(kv1),
    .key_code(code1), .key_rd(key_rd), .fifo_count(cnt1), .last_key(last1),
    .overflow(ovf1), .interrupt(irq1)
  );

  // Key matrix: a closed key pulls its column low only while its row is driven low.
  always_comb begin
    sense0 = '1;
    sense1 = '1;
    for (int r = 0; r < ND; r++) begin
      for (int c = 0; c < NS; c++) begin
        if (pressed && key == r * NS + c) begin
          if (!drive0[r]) sense0[c] = 1'b0;
          if (!drive1[r]) sense1[c] = 1'b0;
        end
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      pulses     <= 0;
      long_pulse <= 1'b0;
      irq1_prev  <= 1'b0;
    end else begin
      irq1_prev <= irq1;
      if (irq1 && !irq1_prev) pulses <= pulses + 1;
      if (irq1 && irq1_prev)  long_pulse <= 1'b1;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Returns #1 after the clk edge on which the DUT acts on a scan tick.
  task automatic wait_tick();
    do begin
      @(posedge clk);
      #1;
    end while (edge_cnt % SD != 0);
  endtask

  task automatic wait_row(input int r);
    int n = 0;
    do begin
      wait_tick();
      n++;
    end while (drive0[r[1:0]] != 1'b0 && n <= ND);
    check("row.sync", int'(drive0[r[1:0]]), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    key_rd = 1'b0;
    pressed = 1'b0;
    q.delete();
    exp_ovf = 0;
    exp_last = 0;
    exp_pulses = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.drive", drive0, 4'b1110);
    check("reset.valid", kv0, 0);
    check("reset.count", cnt0, 0);
    check("reset.last", last0, 0);
    check("reset.ovf", ovf0, 0);
    check("reset.irq0", irq0, 0);
    check("reset.irq1", irq1, 0);
    check("reset.count1", cnt1, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic check_state(input string tag);
    check({tag, ".count"}, cnt0, q.size());
    check({tag, ".count1"}, cnt1, q.size());
    check({tag, ".valid"}, kv0, int'(q.size() != 0));
    check({tag, ".irq0"}, irq0, int'(q.size() != 0));
    check({tag, ".ovf"}, ovf0, exp_ovf);
    check({tag, ".last"}, last0, exp_last);
    if (q.size() != 0) check({tag, ".head"}, code0, q[0]);
  endtask

  task automatic model_push(input int k);
    exp_last = k;
    if (q.size() < FD) begin
      q.push_back(k);
      exp_pulses++;
    end else begin
      exp_ovf = 1;
    end
  endtask

  // Holds long enough for the scan to reach the row plus a full debounce, then releases.
  task automatic press_key(input int k, input int extra);
    wait_tick();
    key = k;
    pressed = 1'b1;
    repeat (ND + DB + 1 + extra) wait_tick();
    pressed = 1'b0;
    repeat (DB + 2) wait_tick();
    model_push(k);
  endtask

  task automatic pop_key();
    key_rd = 1'b1;
    @(posedge clk);
    #1 key_rd = 1'b0;
    if (q.size() != 0) begin
      void'(q.pop_front());
      exp_ovf = 0;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [ND-1:0] exp_drv;
    #2;
    do_reset();

    // Idle scan: one drive step per SD clks, rotating the low line upward.
    exp_drv = 4'b1110;
    for (int i = 0; i < 4 * int'(SD); i++) begin
      @(posedge clk);
      #1;
      if ((i % int'(SD)) == int'(SD) - 1) exp_drv = {exp_drv[ND-2:0], exp_drv[ND-1]};
      check("idle.drive", drive0, exp_drv);
    end
    check("idle.valid", kv0, 0);
    check("idle.irq", irq0, 0);

    // Key 7 = row 2, column 1.
    wait_row(2);
    key = 7;
    pressed = 1'b1;
    repeat (DB) wait_tick();
    check("k7.early", kv0, 0);
    @(posedge clk);
    #1;
    model_push(7);
    check_state("k7");
    check("k7.drive", drive0, 4'b1011);
    check("k7.pulse", irq1, 1);
    @(posedge clk);
    #1;
    check("k7.pulse_end", irq1, 0);
    repeat (4) wait_tick();
    check_state("k7.held");
    check("k7.drive_held", drive0, 4'b1011);
    pressed = 1'b0;
    repeat (DB + 1) wait_tick();
    pop_key();
    check_state("k7.pop");

    // Bounce on key 4: 2 ticks low, 1 high, 3 low.
    wait_row(1);
    key = 4;
    pressed = 1'b1;
    repeat (2) wait_tick();
    pressed = 1'b0;
    wait_tick();
    check("bounce.none", cnt0, 0);
    pressed = 1'b1;
    repeat (3) wait_tick();
    @(posedge clk);
    #1;
    model_push(4);
    check_state("bounce.push");
    repeat (DB + 2) wait_tick();
    pressed = 1'b0;
    repeat (2) wait_tick();
    pressed = 1'b1;
    repeat (DB) wait_tick();
    check_state("bounce.short_rel");
    check("bounce.drive", drive0, 4'b1101);
    pressed = 1'b0;
    repeat (DB + 1) wait_tick();
    check("bounce.released", int'(drive0[1]), 1);
    press_key(4, 0);
    check_state("bounce.again");
    pop_key();
    pop_key();
    check_state("bounce.drain");

    // Overflow: five keys, no reads.
    press_key(1, 0);
    press_key(4, 1);
    press_key(8, 0);
    press_key(11, 2);
    press_key(2, 0);
    check_state("ovf.full");
    for (int i = 0; i < 4; i++) begin
      pop_key();
      check_state("ovf.pop");
    end

    // Full FIFO with push and pop on the same clk.
    press_key(3, 0);
    press_key(5, 0);
    press_key(9, 0);
    press_key(10, 0);
    check_state("same.full");
    wait_row(2);
    key = 6;
    pressed = 1'b1;
    repeat (DB) wait_tick();
    key_rd = 1'b1;
    @(posedge clk);
    #1 key_rd = 1'b0;
    void'(q.pop_front());
    model_push(6);
    check_state("same.clk");
    pressed = 1'b0;
    repeat (DB + 2) wait_tick();
    while (q.size() != 0) pop_key();
    check_state("same.drain");

    for (int it = 0; it < 16; it++) begin
      int k;
      int extra;
      k = int'($urandom_range(0, ND * NS - 1));
      extra = int'($urandom_range(0, 3));
      press_key(k, extra);
      check_state("rand.press");
      repeat ($urandom_range(0, 2)) pop_key();
      check_state("rand.pop");
    end

    check("irq1.pulses", pulses, exp_pulses);
    check("irq1.width", int'(long_pulse), 0);

    // Reset while debouncing a press: nothing may be queued afterwards.
    wait_row(0);
    key = 0;
    pressed = 1'b1;
    repeat (2) wait_tick();
    do_reset();
    repeat (2 * DB + ND) wait_tick();
    check_state("rst_db");
    check("rst_db.pulses", pulses, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
